// File: rtl/rob.sv
// Reorder buffer: allocates ids at dispatch, captures ALU/LSB broadcasts,
// retires in program order and flushes everything on a mispredicted branch.
module rob #(
    parameter int ROB_SIZE  = 8,
    parameter int ROB_WIDTH = 3
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    output logic                 rob_full,
    output logic [ROB_WIDTH-1:0] tail_id,
    input  logic                 dec_ready,
    input  logic [1:0]           dec_kind,
    input  logic [4:0]           dec_rd,
    input  logic [31:0]          dec_pred_addr,
    input  logic                 rs_ready,
    input  logic [ROB_WIDTH-1:0] rs_rob_id,
    input  logic [31:0]          rs_value,
    input  logic                 lsb_ready,
    input  logic [ROB_WIDTH-1:0] lsb_rob_id,
    input  logic [31:0]          lsb_value,
    input  logic [ROB_WIDTH-1:0] qry_j_id,
    input  logic [ROB_WIDTH-1:0] qry_k_id,
    output logic                 qry_j_ready,
    output logic                 qry_k_ready,
    output logic [31:0]          qry_j_value,
    output logic [31:0]          qry_k_value,
    output logic                 commit_valid,
    output logic [ROB_WIDTH-1:0] commit_rob_id,
    output logic [4:0]           commit_rd,
    output logic [31:0]          commit_value,
    output logic                 commit_store,
    output logic                 clear,
    output logic [31:0]          redirect_pc
);

    localparam logic [1:0] KIND_BRANCH = 2'd1;
    localparam logic [1:0] KIND_STORE  = 2'd2;

    logic [ROB_SIZE-1:0]  busy;
    logic [ROB_SIZE-1:0]  ready;
    logic [1:0]           kind  [ROB_SIZE];
    logic [4:0]           rd    [ROB_SIZE];
    logic [31:0]          value [ROB_SIZE];
    logic [31:0]          pred  [ROB_SIZE];
    logic [ROB_WIDTH-1:0] head;
    logic [ROB_WIDTH-1:0] tail;
    logic [ROB_WIDTH:0]   count;

    logic do_alloc;
    logic do_commit;
    logic mispredict;
    logic head_writes_rd;

    assign rob_full       = (count == (ROB_WIDTH+1)'(ROB_SIZE));
    assign tail_id        = tail;
    assign do_alloc       = rdy_in && dec_ready && !rob_full && !clear;
    assign do_commit      = rdy_in && busy[head] && ready[head];
    assign mispredict     = do_commit && (kind[head] == KIND_BRANCH) && (value[head] != pred[head]);
    assign head_writes_rd = (kind[head] != KIND_BRANCH) && (kind[head] != KIND_STORE);

    // Returns {ready, value}; a stored result beats the live broadcasts.
    function automatic logic [32:0] lookup(input logic [ROB_WIDTH-1:0] id);
        logic stored;
        logic hit_rs;
        logic hit_lsb;
        logic [32:0] r;
        stored  = busy[id] && ready[id];
        hit_rs  = rs_ready && (rs_rob_id == id);
        hit_lsb = lsb_ready && (lsb_rob_id == id);
        r = {stored || hit_rs || hit_lsb, value[id]};
        if (!stored) begin
            if (hit_rs)
                r[31:0] = rs_value;
            else if (hit_lsb)
                r[31:0] = lsb_value;
        end
        return r;
    endfunction

    always_comb begin
        {qry_j_ready, qry_j_value} = lookup(qry_j_id);
        {qry_k_ready, qry_k_value} = lookup(qry_k_id);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            busy          <= '0;
            ready         <= '0;
            commit_valid  <= 1'b0;
            commit_rob_id <= '0;
            commit_rd     <= '0;
            commit_value  <= '0;
            commit_store  <= 1'b0;
            clear         <= 1'b0;
            redirect_pc   <= '0;
        end else if (rdy_in) begin
            commit_valid <= do_commit;
            commit_store <= do_commit && (kind[head] == KIND_STORE);
            clear        <= mispredict;
            if (do_commit) begin
                commit_rob_id <= head;
                commit_rd     <= head_writes_rd ? rd[head] : 5'd0;
                commit_value  <= value[head];
                busy[head]    <= 1'b0;
                head          <= head + 1'b1;
            end
            if (mispredict)
                redirect_pc <= value[head];

            // LSB is written last so it wins a same-id collision with the ALU.
            if (rs_ready && busy[rs_rob_id]) begin
                value[rs_rob_id] <= rs_value;
                ready[rs_rob_id] <= 1'b1;
            end
            if (lsb_ready && busy[lsb_rob_id]) begin
                value[lsb_rob_id] <= lsb_value;
                ready[lsb_rob_id] <= 1'b1;
            end

            if (do_alloc) begin
                busy[tail]  <= 1'b1;
                ready[tail] <= 1'b0;
                kind[tail]  <= dec_kind;
                rd[tail]    <= dec_rd;
                pred[tail]  <= dec_pred_addr;
                tail        <= tail + 1'b1;
            end

            case ({do_alloc, do_commit})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            // A flush overrides any concurrent allocate or retire bookkeeping.
            if (mispredict) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
                busy  <= '0;
            end
        end
    end

endmodule
